// File: rtl/multi_combiner.sv
// multi_combiner: N independent per-channel FIFOs whose heads are joined into one
// N*WIDTH-bit word and presented through a single registered output stage.
module multi_combiner #(
    parameter int    N     = 2,
    parameter int    WIDTH = 4,
    parameter int    DEPTH = 2,
    parameter string BURST = "yes"
) (
    input  logic                         iCLK,
    input  logic                         iRST,
    input  logic [N-1:0]                 iValid_AM,
    output logic [N-1:0]                 oReady_AM,
    input  logic [N*WIDTH-1:0]           iData_AM,
    output logic                         oValid_BM,
    input  logic                         iReady_BM,
    output logic [N*WIDTH-1:0]           oData_BM,
    output logic [N*$clog2(DEPTH+1)-1:0] oLevel_AM
);

    localparam int PtrW      = $clog2(DEPTH);
    localparam int LvlW      = $clog2(DEPTH + 1);
    localparam bit BurstMode = (BURST == "yes");

    logic [N-1:0]       full;
    logic [N-1:0]       notEmpty;
    logic [N-1:0]       push;
    logic [N*WIDTH-1:0] heads;
    logic               fire;

    // Ready depends only on occupancy and reset, never on valid or downstream ready.
    assign oReady_AM = {N{iRST}} & ~full;
    assign push      = iValid_AM & oReady_AM;

    // In non-burst mode the stage only reloads once it has been emptied, halving throughput.
    assign fire = (&notEmpty) && (!oValid_BM || (BurstMode && iReady_BM));

    for (genvar g = 0; g < N; g++) begin : gChan
        logic [WIDTH-1:0] mem [DEPTH];
        logic [PtrW-1:0]  rdPtr;
        logic [PtrW-1:0]  wrPtr;
        logic [LvlW-1:0]  level;

        assign full[g]                    = (level == LvlW'(DEPTH));
        assign notEmpty[g]                = (level != '0);
        assign heads[g*WIDTH +: WIDTH]    = mem[rdPtr];
        assign oLevel_AM[g*LvlW +: LvlW]  = level;

        always_ff @(posedge iCLK or negedge iRST) begin
            if (!iRST) begin
                rdPtr <= '0;
                wrPtr <= '0;
                level <= '0;
            end else begin
                if (push[g]) wrPtr <= wrPtr + PtrW'(1);
                if (fire)    rdPtr <= rdPtr + PtrW'(1);
                level <= level + LvlW'(push[g]) - LvlW'(fire);
            end
        end

        // NOTE: storage is deliberately not reset; the occupancy counter alone marks valid entries.
        always_ff @(posedge iCLK) begin
            if (push[g]) mem[wrPtr] <= iData_AM[g*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oValid_BM <= 1'b0;
            oData_BM  <= '0;
        end else if (fire) begin
            oValid_BM <= 1'b1;
            oData_BM  <= heads;
        end else if (iReady_BM) begin
            oValid_BM <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_combiner.sv
// Bench for multi_combiner: three instances (N=2 burst, N=3 burst, N=3 non-burst) checked
// every cycle against a queue-based model, plus directed scenarios with literal expectations.
module tb_multi_combiner;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    logic [2:0]  inV  [3];
    logic [11:0] inD  [3];
    logic        inR  [3];
    logic [2:0]  outR [3];
    logic        outV [3];
    logic [11:0] outD [3];
    logic [5:0]  outL [3];

    logic [1:0]  rdyA;
    logic [7:0]  dataA;
    logic [3:0]  lvlA;
    logic        vA, vB, vC;
    logic [2:0]  rdyB, rdyC;
    logic [11:0] dataB, dataC;
    logic [5:0]  lvlB, lvlC;

    multi_combiner #(.N(2), .WIDTH(4), .DEPTH(DEPTH), .BURST("yes")) dutA (
        .iCLK(clk), .iRST(rstN), .iValid_AM(inV[0][1:0]), .oReady_AM(rdyA),
        .iData_AM(inD[0][7:0]), .oValid_BM(vA), .iReady_BM(inR[0]),
        .oData_BM(dataA), .oLevel_AM(lvlA));

    multi_combiner #(.N(3), .WIDTH(4), .DEPTH(DEPTH), .BURST("yes")) dutB (
        .iCLK(clk), .iRST(rstN), .iValid_AM(inV[1]), .oReady_AM(rdyB),
        .iData_AM(inD[1]), .oValid_BM(vB), .iReady_BM(inR[1]),
        .oData_BM(dataB), .oLevel_AM(lvlB));

    multi_combiner #(.N(3), .WIDTH(4), .DEPTH(DEPTH), .BURST("no")) dutC (
        .iCLK(clk), .iRST(rstN), .iValid_AM(inV[2]), .oReady_AM(rdyC),
        .iData_AM(inD[2]), .oValid_BM(vC), .iReady_BM(inR[2]),
        .oData_BM(dataC), .oLevel_AM(lvlC));

    assign outR[0] = {1'b0, rdyA};
    assign outV[0] = vA;
    assign outD[0] = {4'h0, dataA};
    assign outL[0] = {2'b00, lvlA};
    assign outR[1] = rdyB;
    assign outV[1] = vB;
    assign outD[1] = dataB;
    assign outL[1] = lvlB;
    assign outR[2] = rdyC;
    assign outV[2] = vC;
    assign outD[2] = dataC;
    assign outL[2] = lvlC;

    // Reference model: one queue per channel, plus the output word of each instance.
    int          nCh   [3] = '{2, 3, 3};
    bit          burst [3] = '{1'b1, 1'b1, 1'b0};
    logic [3:0]  q     [3][3][$];
    logic        mV    [3];
    logic [11:0] mD    [3];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clearModel();
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 3; c++) q[k][c].delete();
            mV[k] = 1'b0;
            mD[k] = '0;
        end
    endtask

    always @(negedge rstN) clearModel();

    always @(posedge clk) begin
        if (rstN) begin
            for (int k = 0; k < 3; k++) begin
                bit          doFire;
                bit          canAcc [3];
                logic [11:0] word;
                doFire = 1'b1;
                word   = '0;
                for (int c = 0; c < nCh[k]; c++) begin
                    if (q[k][c].size() == 0) doFire = 1'b0;
                    canAcc[c] = (q[k][c].size() < DEPTH);
                end
                if (mV[k] && !(burst[k] && inR[k])) doFire = 1'b0;
                if (doFire)
                    for (int c = 0; c < nCh[k]; c++) word[c*4 +: 4] = q[k][c].pop_front();
                for (int c = 0; c < nCh[k]; c++)
                    if (canAcc[c] && inV[k][c]) q[k][c].push_back(inD[k][c*4 +: 4]);
                if (doFire) begin
                    mV[k] = 1'b1;
                    mD[k] = word;
                end else if (mV[k] && inR[k]) begin
                    mV[k] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            logic [2:0] expR;
            logic [5:0] expL;
            expR = '0;
            expL = '0;
            for (int c = 0; c < nCh[k]; c++) begin
                expR[c]       = rstN && (q[k][c].size() < DEPTH);
                expL[c*2 +: 2] = 2'(q[k][c].size());
            end
            check($sformatf("model_ready_%0d", k), 32'(outR[k]), 32'(expR));
            check($sformatf("model_valid_%0d", k), 32'(outV[k]), 32'(mV[k]));
            check($sformatf("model_data_%0d", k),  32'(outD[k]), 32'(mD[k]));
            check($sformatf("model_level_%0d", k), 32'(outL[k]), 32'(expL));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic randomCycles(input int n, input bit holdA);
        for (int t = 0; t < n; t++) begin
            for (int k = 0; k < 3; k++) begin
                for (int c = 0; c < 3; c++) inV[k][c] = ($urandom_range(0, 9) < 7);
                inD[k] = 12'($urandom);
                inR[k] = ($urandom_range(0, 9) < 6);
            end
            if (holdA) inR[0] = 1'b0;
            tick();
        end
    endtask

    function automatic logic [11:0] streamWord(input int n);
        return {4'(3 + n), 4'(2 + n), 4'(1 + n)};
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] sCnt [3][3];
        logic [2:0] acc  [3];
        int         seenB, seenC;
        bit         prevC, found;

        rstN = 1'b0;
        for (int k = 0; k < 3; k++) begin
            inV[k] = '0;
            inD[k] = '0;
            inR[k] = 1'b1;
        end
        clearModel();
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid_A", 32'(vA), 0);
        check("rst_data_B",  32'(dataB), 0);
        check("rst_ready_C", 32'(rdyC), 0);
        check("rst_level_B", 32'(lvlB), 0);
        rstN = 1'b1;
        #1;
        check("rel_ready_A", 32'(rdyA), 32'h3);
        check("rel_ready_C", 32'(rdyC), 32'h7);
        tick();

        // Streaming on the two N=3 instances: burst gives one word per cycle, non-burst alternates.
        for (int k = 1; k < 3; k++)
            for (int c = 0; c < 3; c++) sCnt[k][c] = 4'(c + 1);
        seenB = 0;
        seenC = 0;
        prevC = 1'b0;
        for (int t = 0; t < 14; t++) begin
            for (int k = 1; k < 3; k++) begin
                inV[k] = 3'b111;
                for (int c = 0; c < 3; c++) inD[k][c*4 +: 4] = sCnt[k][c];
                acc[k] = outR[k];
            end
            tick();
            for (int k = 1; k < 3; k++)
                for (int c = 0; c < 3; c++) if (acc[k][c]) sCnt[k][c] = sCnt[k][c] + 4'd1;
            if (vB) begin
                check("stream_B_data", 32'(dataB), 32'(streamWord(seenB)));
                seenB++;
            end else if (seenB > 0) begin
                check("stream_B_bubble", 32'(vB), 1);
            end
            if (vC) begin
                check("stream_C_data", 32'(dataC), 32'(streamWord(seenC)));
                check("stream_C_back2back", 32'(prevC), 0);
                seenC++;
            end else if (seenC > 0) begin
                check("stream_C_gap", 32'(prevC), 1);
            end
            prevC = vC;
        end
        check("stream_B_count", seenB, 13);
        check("stream_C_count", seenC, 7);
        inV[1] = '0;
        inV[2] = '0;
        repeat (6) tick();

        // Staggered arrival on the N=2 instance.
        inV[0] = 3'b001; inD[0] = 12'h00A; tick();
        check("stag_level1", 32'(lvlA), 32'h1);
        check("stag_valid1", 32'(vA), 0);
        inV[0] = 3'b010; inD[0] = 12'h0B0; tick();
        check("stag_valid2", 32'(vA), 0);
        check("stag_level2", 32'(lvlA), 32'h5);
        inV[0] = 3'b000; tick();
        check("stag_valid3", 32'(vA), 1);
        check("stag_data3",  32'(dataA), 32'hBA);
        check("stag_level3", 32'(lvlA), 0);
        tick();
        check("stag_valid4", 32'(vA), 0);
        check("stag_data4",  32'(dataA), 32'hBA);

        // Backpressure: ch0 fills, ch1 completes the word, word waits for downstream ready.
        inR[0] = 1'b0; inV[0] = 3'b001; inD[0] = 12'h007;
        check("bp_ready_start", 32'(rdyA), 32'h3);
        tick(); tick();
        check("bp_ready_full", 32'(rdyA), 32'h2);
        check("bp_level_full", 32'(lvlA), 32'h2);
        tick();
        check("bp_level_refused", 32'(lvlA), 32'h2);
        inV[0] = 3'b010; inD[0] = 12'h080; tick();
        check("bp_level_ch1", 32'(lvlA), 32'h6);
        inV[0] = 3'b000; tick();
        check("bp_valid_fire", 32'(vA), 1);
        check("bp_data_fire",  32'(dataA), 32'h87);
        check("bp_level_fire", 32'(lvlA), 32'h1);
        tick();
        check("bp_valid_hold", 32'(vA), 1);
        check("bp_data_hold",  32'(dataA), 32'h87);
        inR[0] = 1'b1; tick();
        check("bp_valid_taken", 32'(vA), 0);
        inV[0] = 3'b010; inD[0] = 12'h080; tick();
        inV[0] = 3'b000; tick();
        check("bp_valid_again", 32'(vA), 1);
        check("bp_data_again",  32'(dataA), 32'h87);
        tick();
        check("bp_valid_end", 32'(vA), 0);

        // Full FIFO 0 with a fire in the same cycle: push refused, then accepted next edge.
        inV[0] = 3'b001; inD[0] = 12'h001; tick();
        inD[0] = 12'h002; tick();
        check("full_level_start", 32'(lvlA), 32'h2);
        inV[0] = 3'b011; inD[0] = 12'h053; tick();
        check("full_level_a", 32'(lvlA), 32'h6);
        inV[0] = 3'b001; inD[0] = 12'h003; tick();
        check("full_level_b", 32'(lvlA), 32'h1);
        check("full_data_b",  32'(dataA), 32'h51);
        check("full_ready_b", 32'(rdyA), 32'h3);
        tick();
        check("full_level_c", 32'(lvlA), 32'h2);
        check("full_valid_c", 32'(vA), 0);
        inV[0] = 3'b000;

        randomCycles(500, 1'b0);

        // Reset in the middle of traffic while A holds a word and has buffered entries.
        found = 1'b0;
        for (int t = 0; t < 200 && !found; t++) begin
            randomCycles(1, 1'b1);
            if (vA && lvlA != 4'h0) found = 1'b1;
        end
        check("midrst_setup", 32'(found), 1);
        rstN = 1'b0;
        #1;
        check("midrst_valid_A", 32'(vA), 0);
        check("midrst_data_A",  32'(dataA), 0);
        check("midrst_level_A", 32'(lvlA), 0);
        check("midrst_ready_A", 32'(rdyA), 0);
        check("midrst_valid_B", 32'(vB), 0);
        check("midrst_level_C", 32'(lvlC), 0);
        for (int k = 0; k < 3; k++) begin
            inV[k] = '0;
            inR[k] = 1'b1;
        end
        tick();
        rstN = 1'b1;
        #1;
        check("midrst_release_ready", 32'(rdyA), 32'h3);
        repeat (3) begin
            tick();
            check("midrst_no_stale", 32'(vA), 0);
        end

        randomCycles(400, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_combiner.md
MULTI_COMBINER -- requirements
Module: multi_combiner

Interface
REQ-001 SHALL have parameter N, default 2: number of input channels, 2..8.
REQ-002 SHALL have parameter WIDTH, default 4: data width per channel, 1..64.
REQ-003 SHALL have parameter DEPTH, default 2: per-channel FIFO entries, power of 2, 2..16.
REQ-004 SHALL have parameter BURST, default "yes": "yes" gives full throughput; "no" gives at most one output every 2 cycles.
REQ-005 SHALL have port iCLK, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port iRST, input, 1 bit: asynchronous reset, active-low.
REQ-007 SHALL have port iValid_AM, input, N bits: bit i is the valid for channel i.
REQ-008 SHALL have port oReady_AM, output, N bits: bit i is the ready for channel i.
REQ-009 SHALL have port iData_AM, input, N*WIDTH bits: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port oValid_BM, output, 1 bit: combined word valid.
REQ-011 SHALL have port iReady_BM, input, 1 bit: downstream ready.
REQ-012 SHALL have port oData_BM, output, N*WIDTH bits: combined word, channel 0 in the LSBs.
REQ-013 SHALL have port oLevel_AM, output, N*$clog2(DEPTH+1) bits: per-channel FIFO occupancy, for debug and status.

Function
REQ-014 SHALL accept a word on channel i at a rising edge where iValid_AM[i]=1 and oReady_AM[i]=1, and write it to FIFO i.
REQ-015 SHALL drive oReady_AM[i] as (FIFO i not full) AND (iRST high), with no combinational path from any iValid_AM or iReady_BM.
REQ-016 SHALL define the output stage as a single register holding oValid_BM and oData_BM; an output handshake is oValid_BM=1 and iReady_BM=1 at an edge.
REQ-017 SHALL, with BURST="yes", fire when every FIFO is non-empty AND (oValid_BM=0 OR iReady_BM=1).
REQ-018 SHALL, with BURST="no", fire when every FIFO is non-empty AND oValid_BM=0.
REQ-019 SHALL, on fire, pop exactly one entry from every FIFO, load the output register with the concatenation of the N FIFO heads, and set oValid_BM=1.
REQ-020 SHALL, on an output handshake with no fire in the same cycle, clear oValid_BM to 0; oData_BM SHALL hold its last value.
REQ-021 SHALL keep oValid_BM and oData_BM stable while oValid_BM=1 and iReady_BM=0.
REQ-022 SHALL have a latency of 1 edge: a word written at edge k into the last empty FIFO appears on oData_BM after edge k+1, provided the output stage can accept it.
REQ-023 SHALL NOT bypass input to output in the same cycle; the FIFO is always traversed.
REQ-024 SHALL, on simultaneous push and pop on FIFO i, update data correctly and leave the occupancy unchanged.
REQ-025 SHALL NOT accept a push to a FIFO that is full, even when that FIFO pops in the same cycle; ready deasserts at full.
REQ-026 SHALL wrap the FIFO read and write pointers modulo DEPTH, with occupancy ranging 0..DEPTH.
REQ-027 SHALL make channels fully independent on input: a channel may run ahead by up to DEPTH words while others are empty.
REQ-028 SHALL, with BURST="yes" and all inputs and the output continuously valid and ready, give a sustained throughput of 1 word per cycle; with BURST="no", 1 word per 2 cycles.

Reset
REQ-029 SHALL, while iRST=0, hold all FIFOs empty, oLevel_AM=0, oValid_BM=0, oData_BM=0 and oReady_AM=0, asynchronously.
REQ-030 SHALL drive oReady_AM to all-1 combinationally on iRST rising; the first accept occurs at the next edge.
REQ-031 SHALL, on reset asserted mid-transfer, discard all buffered and output data with no partial word emitted afterward.

Verification
REQ-032 SHALL cover staggered arrival: N=2, WIDTH=4; ch0 sends 0xA at edge 1, ch1 sends 0xB at edge 2, iReady_BM=1 -> oValid_BM=1 with oData_BM=0xBA after edge 3 for one cycle, then oValid_BM=0.
REQ-033 SHALL cover backpressure: N=2, DEPTH=2, iReady_BM=0; ch0 sends 0x7 for 3 cycles -> 2 accepted, oReady_AM[0]=0 after 2 words; ch1 sends 0x8 -> 0x87 held on output; with iReady_BM=1 -> 0x87, then 0x87 again after ch1 resends.
REQ-034 SHALL cover streaming: N=3, WIDTH=4, BURST="yes", all valid, ch i data = 0x1,2,3 incremented per word, iReady_BM=1 -> 0x321, 0x432, ... on consecutive cycles with no bubbles; with BURST="no" -> same sequence, oValid_BM alternating 1/0.
REQ-035 SHALL cover full-FIFO corner: FIFO 0 full, ch0 valid, fire occurring the same cycle -> push refused that edge, accepted on the next edge, oLevel_AM for ch0 going 2->1->2.
REQ-036 SHALL cover reset mid-operation: iRST=0 while oValid_BM=1 and FIFOs partly full -> immediate oValid_BM=0, oData_BM=0, oLevel_AM=0, oReady_AM=0; after release, the stale data never appears.
